// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the memory port arbiter: requester source tags,
// default widths and the read-tag record carried through the tag pipeline.
package mem_port_arbiter_pkg;

    localparam int AW_DEF       = 16;
    localparam int DW_DEF       = 32;
    localparam int RD_LAT_DEF   = 1;
    localparam int MAX_WAIT_DEF = 4;

    localparam logic SRC_IF = 1'b0;
    localparam logic SRC_LS = 1'b1;

    typedef struct packed {
        logic valid;
        logic src;
    } rd_tag_t;

    function automatic rd_tag_t make_tag(input logic valid, input logic src);
        rd_tag_t t;
        t.valid = valid;
        t.src   = src;
        return t;
    endfunction

endpackage

// File: rtl/mem_rd_tag_pipe.sv
// RD_LAT-deep shift register of {valid, src} read tags with synchronous clear;
// the last stage lines up with the cycle the Memory returns the matching data.
module mem_rd_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load_valid_i,
    input  logic load_src_i,
    output logic exit_valid_o,
    output logic exit_src_o
);

    rd_tag_t [DEPTH-1:0] pipe_q;

    // Shift a new tag in every cycle; an empty slot is an invalid tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_q <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            pipe_q[0] <= make_tag(load_valid_i, load_src_i);
        end
    end

    assign exit_valid_o = pipe_q[DEPTH-1].valid;
    assign exit_src_o   = pipe_q[DEPTH-1].src;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port Memory between instruction fetch (IF) and load/store (LS),
// routing read data back to its issuer. Optional LS address window check: MEM_ARB_BOUNDS_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int RD_LAT   = RD_LAT_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_err,
    input  logic [AW-1:0] lim_lo,
    input  logic [AW-1:0] lim_hi,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic       if_win_s;
    logic       ls_win_s;
    logic       ls_oob_s;
    logic       tag_load_s;
    logic       tag_src_s;
    logic       exit_valid_s;
    logic       exit_src_s;
    logic [3:0] wait_cnt_q;
    logic [3:0] wait_cnt_d;

`ifdef MEM_ARB_BOUNDS_EN
    logic ls_err_q;
    logic ls_err_d;

    // LS window check; IF fetches are never bounds-checked.
    always_comb begin
        ls_oob_s = (ls_addr < lim_lo) || (ls_addr > lim_hi);
        ls_err_d = ls_win_s && ls_oob_s;
    end

    // One-cycle error pulse following a rejected LS access.
    always_ff @(posedge clk) begin
        if (reset) begin
            ls_err_q <= 1'b0;
        end else begin
            ls_err_q <= ls_err_d;
        end
    end

    assign ls_err = ls_err_q && !reset;
`else
    logic unused_lim_s;

    assign unused_lim_s = ^{lim_lo, lim_hi};
    assign ls_oob_s     = 1'b0;
    assign ls_err       = 1'b0;
`endif

    // Grant selection: LS has priority unless IF has waited MAX_WAIT cycles.
    always_comb begin
        if_win_s = 1'b0;
        ls_win_s = 1'b0;
        if (reset) begin
            if_win_s = 1'b0;
            ls_win_s = 1'b0;
        end else if (if_req && (!ls_req || (wait_cnt_q == MAX_WAIT_C))) begin
            if_win_s = 1'b1;
        end else if (ls_req) begin
            ls_win_s = 1'b1;
        end else begin
            if_win_s = 1'b0;
            ls_win_s = 1'b0;
        end
    end

    assign if_gnt = if_win_s;
    assign ls_gnt = ls_win_s;

    // Drive the Memory port and the read tag for this cycle's winner.
    always_comb begin
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        tag_load_s = 1'b0;
        tag_src_s  = SRC_IF;
        if (if_win_s) begin
            mem_addr   = if_addr;
            tag_load_s = 1'b1;
            tag_src_s  = SRC_IF;
        end else if (ls_win_s) begin
            mem_wdata = ls_wdata;
            tag_src_s = SRC_LS;
            if (!ls_oob_s) begin
                mem_addr   = ls_addr;
                mem_we     = ls_we;
                tag_load_s = !ls_we;
            end else begin
                tag_load_s = 1'b0;
            end
        end else begin
            tag_load_s = 1'b0;
        end
    end

    // IF starvation counter: counts consecutive denied cycles, saturating at MAX_WAIT.
    always_comb begin
        wait_cnt_d = 4'd0;
        if (if_req && !if_win_s) begin
            if (wait_cnt_q == MAX_WAIT_C) begin
                wait_cnt_d = wait_cnt_q;
            end else begin
                wait_cnt_d = wait_cnt_q + 4'd1;
            end
        end else begin
            wait_cnt_d = 4'd0;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    mem_rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk          (clk),
        .reset        (reset),
        .load_valid_i (tag_load_s),
        .load_src_i   (tag_src_s),
        .exit_valid_o (exit_valid_s),
        .exit_src_o   (exit_src_s)
    );

    // Steer returning read data to the requester recorded in the exiting tag.
    always_comb begin
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rdata  = '0;
        if (!reset && exit_valid_s) begin
            if (exit_src_s == SRC_LS) begin
                ls_rvalid = 1'b1;
                ls_rdata  = mem_rdata;
            end else begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
        end else begin
            if_rvalid = 1'b0;
            ls_rvalid = 1'b0;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port Memory between two requesters: the Controller's instruction fetch (IF, read-only) and the DataPath load/store unit (LS, read/write).
- Arbitrates once per cycle and drives the Memory address, write-data and write-enable.
- Tracks in-flight reads through a tag pipeline so each read result returns only to its issuer.
- Sits between Controller/DataPath and Memory in the OSECPU top.

Parameters:
AW, 16, address width (matches Memory addr)
DW, 32, data width
RD_LAT, 1, Memory read latency in cycles (legal values 1 or 2)
MAX_WAIT, 4, consecutive cycles IF may be denied before it is forced a grant (1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch read request
if_addr  in  AW  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch read data valid
if_rdata  out  DW  fetch read data
ls_req  in  1  load/store request
ls_we  in  1  1 = store, 0 = load
ls_addr  in  AW  load/store address
ls_wdata  in  DW  store data
ls_gnt  out  1  load/store request accepted this cycle
ls_rvalid  out  1  load data valid
ls_rdata  out  DW  load data
ls_err  out  1  access rejected (only with MEM_ARB_BOUNDS_EN)
lim_lo  in  AW  lowest legal LS address (used only with MEM_ARB_BOUNDS_EN)
lim_hi  in  AW  highest legal LS address (used only with MEM_ARB_BOUNDS_EN)
mem_addr  out  AW  Memory address
mem_wdata  out  DW  Memory write data
mem_we  out  1  Memory write enable
mem_rdata  in  DW  Memory read data, valid RD_LAT cycles after its address

Behaviour:
- Reset: all outputs 0; starvation counter 0; tag pipeline cleared.
  - Reset mid-operation discards in-flight reads; no rvalid for them is ever produced.
- Grant logic is combinational from req and registered state. A request is accepted in any cycle where its gnt is 1; a requester holds req, addr and data until it sees gnt.
- Priority: LS wins over IF, except when wait_cnt == MAX_WAIT, in which case IF wins.
- wait_cnt (4-bit register):
  - increments when if_req=1 and if_gnt=0;
  - clears when if_gnt=1 or if_req=0;
  - saturates at MAX_WAIT.
- Exactly one gnt per cycle at most; none when neither requester is active.
- Issue, same cycle as gnt:
  - mem_addr = winner's addr.
  - mem_we = ls_we when LS wins, else 0.
  - mem_wdata = ls_wdata when LS wins, else 0.
  - With no grant: mem_addr = 0, mem_we = 0, mem_wdata = 0.
- Tag pipeline: an RD_LAT-deep shift register of 2-bit tags {valid, src}. It is loaded on every read grant (IF, or LS with ls_we=0).
  - At pipeline exit: src=IF pulses if_rvalid for 1 cycle with if_rdata = mem_rdata; src=LS does the same on ls_rvalid/ls_rdata.
  - rdata outputs are 0 when the matching rvalid is 0.
- Stores produce no rvalid. They complete on the grant cycle.
- Throughput: one access per cycle; back-to-back reads from either source are fully pipelined. Read data returns in issue order.
- Write-then-read to the same address on consecutive cycles returns the new data, relying on Memory write-first behaviour.
- If ls_req and if_req are asserted every cycle, IF is granted exactly 1 cycle in every MAX_WAIT+1.

Optional Feature:
MEM_ARB_BOUNDS_EN
- Defined: an LS access with ls_addr < lim_lo or ls_addr > lim_hi is still granted (ls_gnt=1), but:
  - mem_we is forced to 0 and mem_addr to 0;
  - no tag is loaded;
  - ls_err is registered high for the following cycle (1-cycle pulse).
  - IF is never checked.
- Undefined: ls_err is tied 0, lim_lo/lim_hi are ignored, and no comparators are synthesised.

Decomposition:
- Shared package/include (def.v): source tag constants SRC_IF=1'b0 and SRC_LS=1'b1, and default widths.
- One natural sub-module: mem_rd_tag_pipe (the RD_LAT-deep valid/src shift register with synchronous clear).

Test Plan:
1. IF-only reads: if_req=1, addr 0x0000..0x0003 on consecutive cycles -> if_gnt=1 each cycle; if_rvalid with mem[0..3] arrives RD_LAT cycles after each gnt.
2. Contention: both req=1 continuously, MAX_WAIT=4 -> grant sequence LS,LS,LS,LS,IF repeating; wait_cnt returns to 0 after each IF grant.
3. Store then load: LS store 0xDEADBEEF @0x0010, next cycle LS load @0x0010 -> mem_we=1 for one cycle, then ls_rvalid with 0xDEADBEEF; no if_rvalid.
4. Interleaved reads: IF read @0x0020 followed by LS read @0x0030 -> if_rvalid carries only mem[0x20] and ls_rvalid carries only mem[0x30], in issue order.
5. Reset mid-flight: assert reset on the cycle after a read grant -> no rvalid on either port afterwards; all outputs 0 during reset.
6. (MEM_ARB_BOUNDS_EN) lim_lo=0x0100, lim_hi=0x01FF, LS store @0x0200 -> ls_gnt=1, mem_we=0, ls_err=1 next cycle, memory unchanged.
